// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and FSM encoding for the serializer and detector benches
package seq_pkg;

  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_DEPTH    = 4;
  localparam logic DEF_IDLE_BIT = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered occupancy and head-of-queue read data
module sync_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  // Writes into a full FIFO and reads from an empty one are dropped rather than corrupting state.
  assign w_do_wr = wr_en && !full && !rst;
  assign w_do_rd = rd_en && !empty && !rst;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  // Head entry is visible combinationally so a pop can load it at the same edge.
  assign rd_data = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bit_serializer_fifo.sv
// rtl/bit_serializer_fifo.sv - buffered parallel-to-serial front end feeding the sequence detectors
module bit_serializer_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   word_start,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BIT_W = $clog2(WIDTH);

  shift_state_e     r_state;
  shift_state_e     w_state_nxt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_word_start;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_head;

  // Readiness deliberately ignores a same-cycle pop so the handshake has no path through the FSM.
  assign din_ready  = !w_full && !rst;
  assign w_push     = din_valid && din_ready;
  assign w_last_bit = (r_bit_cnt == BIT_W'(WIDTH - 1));

  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign word_start = r_word_start;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (din),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pop decision: load from IDLE when data waits, or chain at the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: r_shift holds the bits not yet presented, so the head bit is always at the output end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_ser_out    <= IDLE_BIT;
      r_ser_valid  <= 1'b0;
      r_word_start <= 1'b0;
    end else if (w_pop) begin
      r_bit_cnt    <= '0;
      r_ser_valid  <= 1'b1;
      r_word_start <= 1'b1;
      if (MSB_FIRST) begin
        r_ser_out <= w_head[WIDTH-1];
        r_shift   <= {w_head[WIDTH-2:0], 1'b0};
      end else begin
        r_ser_out <= w_head[0];
        r_shift   <= {1'b0, w_head[WIDTH-1:1]};
      end
    end else if ((r_state == ST_SHIFT) && !w_last_bit) begin
      r_bit_cnt    <= r_bit_cnt + BIT_W'(1);
      r_ser_valid  <= 1'b1;
      r_word_start <= 1'b0;
      if (MSB_FIRST) begin
        r_ser_out <= r_shift[WIDTH-1];
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        r_ser_out <= r_shift[0];
        r_shift   <= {1'b0, r_shift[WIDTH-1:1]};
      end
    end else begin
      r_bit_cnt    <= '0;
      r_ser_out    <= IDLE_BIT;
      r_ser_valid  <= 1'b0;
      r_word_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer_fifo.sv
// tb/tb_bit_serializer_fifo.sv - self-checking bench for bit_serializer_fifo against a timeline model
module tb_bit_serializer_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         din_valid;
  logic [W-1:0] din;

  logic         m_ready, m_out, m_valid, m_ws;
  logic [2:0]   m_cnt;
  logic         l_ready, l_out, l_valid, l_ws;
  logic [2:0]   l_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every accepted word gets a start edge; bit k of it is shown after edge start+k.
  int           ev = 0;
  int           busy_until = 0;
  int           q_start[$];
  logic [W-1:0] q_word[$];
  logic         last_acc;

  always #5 clk = ~clk;

  bit_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .ser_out(m_out), .ser_valid(m_valid), .word_start(m_ws), .fifo_count(m_cnt)
  );

  bit_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .ser_out(l_out), .ser_valid(l_valid), .word_start(l_ws), .fifo_count(l_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ev, got, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    foreach (q_start[i]) if (q_start[i] > ev) n++;
    return n;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    logic exp_ready, acc;
    logic e_valid, e_ws, e_msb, e_lsb;
    int   s, idx;
    @(negedge clk);
    rst = r; din_valid = v; din = d;
    #1;
    exp_ready = (pending() < D) && !r;
    check_eq("din_ready", m_ready, exp_ready);
    check_eq("din_ready_lsb", l_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    ev++;
    if (r) begin
      q_start.delete();
      q_word.delete();
      busy_until = 0;
    end else if (acc) begin
      s = (ev + 1 > busy_until) ? ev + 1 : busy_until;
      busy_until = s + W;
      q_start.push_back(s);
      q_word.push_back(d);
    end
    last_acc = acc;
    while (q_start.size() > 0 && q_start[0] + W <= ev) begin
      void'(q_start.pop_front());
      void'(q_word.pop_front());
    end
    e_valid = 1'b0; e_ws = 1'b0; e_msb = 1'b0; e_lsb = 1'b0;
    foreach (q_start[i]) begin
      if (q_start[i] <= ev && ev < q_start[i] + W) begin
        idx     = ev - q_start[i];
        e_valid = 1'b1;
        e_ws    = (idx == 0);
        e_msb   = q_word[i][W-1-idx];
        e_lsb   = q_word[i][idx];
      end
    end
    #1;
    check_eq("ser_valid", m_valid, e_valid);
    check_eq("ser_out", m_out, e_msb);
    check_eq("word_start", m_ws, e_ws);
    check_eq("fifo_count", m_cnt, pending());
    check_eq("ser_valid_lsb", l_valid, e_valid);
    check_eq("ser_out_lsb", l_out, e_lsb);
    check_eq("word_start_lsb", l_ws, e_ws);
    check_eq("fifo_count_lsb", l_cnt, pending());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [W-1:0] burst [5];
    int guard;
    rst = 1'b1; din_valid = 1'b0; din = '0;
    burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;

    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    // Single word
    cycle(1'b0, 1'b1, 8'hD6);
    idle(12);

    // Burst followed by a stalled word held against a full FIFO
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, burst[i]);
    guard = 0;
    do begin
      cycle(1'b0, 1'b1, 8'h55);
      guard++;
    end while (!last_acc && guard < 50);
    check_eq("stall_accept", last_acc, 1'b1);
    idle(50);

    // Idle gap between two words
    cycle(1'b0, 1'b1, 8'hF0);
    idle(20);
    cycle(1'b0, 1'b1, 8'h0F);
    idle(12);

    // Reset during bit 3 with two words queued; a push attempt during reset is refused
    cycle(1'b0, 1'b1, 8'hC3);
    cycle(1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b1, 8'h22);
    idle(2);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 8'h77);
    idle(12);

    // Bit-order word
    cycle(1'b0, 1'b1, 8'h06);
    idle(12);

    // Random traffic with varying density and rare resets
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 250; i++) begin
        logic r, v;
        r = ($urandom_range(0, 299) == 0);
        v = ($urandom_range(0, 7) < ph + 1);
        cycle(r, v, W'($urandom));
      end
    end
    idle(50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
